// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter_pkg : shared bus/opcode/state types for the ALU arbiter  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_arbiter_pkg;

   localparam int unsigned BUS_WIDTH = 32;

   typedef logic [BUS_WIDTH-1:0] bus_type;

   // Sparse 4-bit encoding; every value not listed is an illegal operation.
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000,
      ALU_NOR  = 4'b1100
   } alu_oper_type;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_type;

   function automatic logic is_legal_op(input alu_oper_type op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_SLTU, ALU_NOR: legal = 1'b1;
         default:                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage : alu_arbiter_pkg
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ArithmeticModule : combinational team ALU, zero result on bad opcode |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module ArithmeticModule
   import alu_arbiter_pkg::*;
(
   input  bus_type      a,
   input  bus_type      b,
   input  alu_oper_type op,
   output bus_type      result,
   output logic         illegal
);

   always_comb begin
      result  = '0;
      illegal = !is_legal_op(op);
      case (op)
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLT:  result = {{(BUS_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(BUS_WIDTH-1){1'b0}}, (a < b)};
         ALU_NOR:  result = ~(a | b);
         default:  result = '0;
      endcase
   end

endmodule : ArithmeticModule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter : round-robin arbiter sharing one ALU between requesters |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ = 2
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  bus_type      req0_a,
   input  bus_type      req0_b,
   input  bus_type      req1_a,
   input  bus_type      req1_b,
   input  alu_oper_type req0_op,
   input  alu_oper_type req1_op,
   output logic         resp0_valid,
   output logic         resp1_valid,
   input  logic         resp0_ready,
   input  logic         resp1_ready,
   output bus_type      resp_result,
   output logic         resp_zero,
   output logic         resp_err,
   output logic         busy
);

   arb_state_type   state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   bus_type         a_q, a_d;
   bus_type         b_q, b_d;
   alu_oper_type    op_q, op_d;
   bus_type         result_q, result_d;
   logic            zero_q, zero_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] resp_valid_q, resp_valid_d;

   logic [NREQ-1:0] req_valid_vec;
   logic [NREQ-1:0] resp_ready_vec;
   logic [NREQ-1:0] grant_vec;
   logic            grant_idx;
   bus_type         alu_result;
   logic            alu_illegal;

   assign req_valid_vec  = {req1_valid, req0_valid};
   assign resp_ready_vec = {resp1_ready, resp0_ready};

   ArithmeticModule u_alu (
      .a       (a_q),
      .b       (b_q),
      .op      (op_q),
      .result  (alu_result),
      .illegal (alu_illegal)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_d       = last_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      result_d     = result_q;
      zero_d       = zero_q;
      err_d        = err_q;
      resp_valid_d = resp_valid_q;
      grant_vec    = '0;
      grant_idx    = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req_valid_vec) begin
               // Contention goes to whoever was not served last; otherwise the lone requester.
               grant_idx            = (&req_valid_vec) ? ~last_q : req_valid_vec[1];
               grant_vec[grant_idx] = 1'b1;
               owner_d              = grant_idx;
               a_d                  = grant_idx ? req1_a  : req0_a;
               b_d                  = grant_idx ? req1_b  : req0_b;
               op_d                 = grant_idx ? req1_op : req0_op;
               state_d              = EXEC;
            end
         end
         EXEC: begin
            result_d              = alu_result;
            zero_d                = (alu_result == '0);
            err_d                 = alu_illegal;
            resp_valid_d[owner_q] = 1'b1;
            state_d               = RESP;
         end
         RESP: begin
            if (resp_ready_vec[owner_q]) begin
               resp_valid_d = '0;
               last_d       = owner_q;
               state_d      = IDLE;
            end
         end
         default: begin
            resp_valid_d = '0;
            state_d      = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= ALU_AND;
         result_q     <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         resp_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // A grant during a reset cycle would be discarded, so it is never advertised.
   assign req0_ready  = grant_vec[0] & ~reset;
   assign req1_ready  = grant_vec[1] & ~reset;
   assign resp0_valid = resp_valid_q[0];
   assign resp1_valid = resp_valid_q[1];
   assign resp_result = result_q;
   assign resp_zero   = zero_q;
   assign resp_err    = err_q;
   assign busy        = busy_q;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter : randomized scoreboard bench for alu_arbiter         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int P_IDLE = 0;
   localparam int P_EXEC = 1;
   localparam int P_RESP = 2;

   typedef struct {
      logic    owner;
      bus_type result;
      logic    zero;
      logic    err;
      int      due;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   bus_type      req0_a, req0_b, req1_a, req1_b;
   alu_oper_type req0_op, req1_op;
   logic         resp0_valid, resp1_valid;
   logic         resp0_ready, resp1_ready;
   bus_type      resp_result;
   logic         resp_zero, resp_err, busy;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   checking = 1'b0;
   bit   log_gnt  = 1'b0;
   exp_t sb[$];
   logic obs_gnt[$];

   int   phase = P_IDLE;
   logic owner = 1'b0;
   logic last  = 1'b1;
   logic gnt0  = 1'b0;
   logic gnt1  = 1'b0;

   alu_arbiter #(.NREQ(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req1_valid  (req1_valid),
      .req0_ready  (req0_ready),
      .req1_ready  (req1_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req0_op     (req0_op),
      .req1_op     (req1_op),
      .resp0_valid (resp0_valid),
      .resp1_valid (resp1_valid),
      .resp0_ready (resp0_ready),
      .resp1_ready (resp1_ready),
      .resp_result (resp_result),
      .resp_zero   (resp_zero),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t ref_op(input logic who, input bus_type a, input bus_type b,
                                   input alu_oper_type op, input int due);
      exp_t e;
      e.owner = who;
      e.err   = 1'b0;
      e.due   = due;
      case (op)
         ALU_AND:  e.result = a & b;
         ALU_OR:   e.result = a | b;
         ALU_ADD:  e.result = a + b;
         ALU_SUB:  e.result = a - b;
         ALU_SLT:  e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
         ALU_NOR:  e.result = ~(a | b);
         default: begin
            e.result = '0;
            e.err    = 1'b1;
         end
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   function automatic bus_type rand_bus();
      bus_type v;
      case ($urandom_range(0, 4))
         0:       v = '0;
         1:       v = '1;
         2:       v = 32'($urandom_range(0, 15));
         default: v = 32'($urandom);
      endcase
      return v;
   endfunction

   function automatic alu_oper_type rand_op();
      logic [3:0] v;
      if ($urandom_range(0, 7) == 0) begin
         v = 4'($urandom_range(0, 15));
      end else begin
         case ($urandom_range(0, 6))
            0:       v = 4'b0000;
            1:       v = 4'b0001;
            2:       v = 4'b0010;
            3:       v = 4'b0110;
            4:       v = 4'b0111;
            5:       v = 4'b1000;
            default: v = 4'b1100;
         endcase
      end
      return alu_oper_type'(v);
   endfunction

   // Transaction-level reference: predicts grants and queues the expected response.
   task automatic model_step();
      logic g, e0, e1, eb;
      exp_t e;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset) begin
         phase = P_IDLE;
         last  = 1'b1;
         sb.delete();
         return;
      end
      e0 = 1'b0;
      e1 = 1'b0;
      eb = (phase != P_IDLE);
      if (log_gnt && (req0_ready || req1_ready)) obs_gnt.push_back(req1_ready);
      case (phase)
         P_IDLE: begin
            if (req0_valid || req1_valid) begin
               g = req0_valid ? (req1_valid ? !last : 1'b0) : 1'b1;
               e0 = !g;
               e1 = g;
               e = g ? ref_op(1'b1, req1_a, req1_b, req1_op, cyc + 2)
                     : ref_op(1'b0, req0_a, req0_b, req0_op, cyc + 2);
               sb.push_back(e);
               owner = g;
               phase = P_EXEC;
               gnt0  = e0;
               gnt1  = e1;
            end
         end
         P_EXEC: phase = P_RESP;
         default: begin
            if (owner ? resp1_ready : resp0_ready) begin
               last  = owner;
               phase = P_IDLE;
            end
         end
      endcase
      n_tests++;
      if ({req0_ready, req1_ready, busy} !== {e0, e1, eb}) begin
         n_fail++;
         $display("FAIL handshake @%0d: ready0/ready1/busy=%b%b%b required %b%b%b",
                  cyc, req0_ready, req1_ready, busy, e0, e1, eb);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: compares every presented response against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (checking && !reset) begin
            n_tests++;
            if (sb.size() != 0 && cyc >= sb[0].due) begin
               e = sb[0];
               if (resp0_valid !== !e.owner || resp1_valid !== e.owner ||
                   resp_result !== e.result || resp_zero !== e.zero || resp_err !== e.err) begin
                  n_fail++;
                  $display("FAIL resp @%0d: v0=%b v1=%b result=%h zero=%b err=%b required owner=%0d result=%h zero=%b err=%b",
                           cyc, resp0_valid, resp1_valid, resp_result, resp_zero, resp_err,
                           e.owner, e.result, e.zero, e.err);
               end
               if (e.owner ? resp1_ready : resp0_ready) void'(sb.pop_front());
            end else if (resp0_valid || resp1_valid) begin
               n_fail++;
               $display("FAIL resp_unexpected @%0d: v0=%b v1=%b required 00", cyc, resp0_valid, resp1_valid);
            end
         end
      end
   end

   task automatic check_grants(input string name, input logic exp_seq[$]);
      n_tests++;
      if (obs_gnt != exp_seq) begin
         n_fail++;
         $display("FAIL %s: grants=%p required %p", name, obs_gnt, exp_seq);
      end
   endtask

   initial begin
      logic exp_seq[$];
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      req0_op = ALU_AND; req1_op = ALU_AND;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_zero, resp_err} !== 7'b0 ||
          resp_result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: flags=%b result=%h required 0000000 result=0",
                  {req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_zero, resp_err}, resp_result);
      end
      @(posedge clk);
      #1 checking = 1'b1;

      // Single ADD from requester 0.
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = ALU_ADD; resp0_ready = 1'b1;
      cycle();
      req0_valid = 1'b0;
      repeat (4) cycle();

      // Contention after reset: requester 0 first, then requester 1.
      reset = 1'b1; cycle(); reset = 1'b0;
      obs_gnt.delete(); log_gnt = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = ALU_SUB;
      req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = ALU_OR;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (gnt0) req0_valid = 1'b0;
         if (gnt1) req1_valid = 1'b0;
      end
      exp_seq = '{1'b0, 1'b1};
      check_grants("contention_order", exp_seq);

      // Both held valid: grants alternate.
      obs_gnt.delete();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 30 && obs_gnt.size() < 4; i++) begin
         cycle();
         if (gnt0) begin req0_a = rand_bus(); req0_b = rand_bus(); req0_op = rand_op(); end
         if (gnt1) begin req1_a = rand_bus(); req1_b = rand_bus(); req1_op = rand_op(); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
      check_grants("round_robin", exp_seq);
      log_gnt = 1'b0;
      repeat (4) cycle();

      // SLTU held in RESP with requester 0 knocking.
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'hFFFF_FFFF; req1_op = ALU_SLTU; resp1_ready = 1'b0;
      cycle();
      req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = ALU_AND;
      repeat (6) cycle();
      resp1_ready = 1'b1;
      cycle();
      req0_valid = 1'b0;
      repeat (5) cycle();

      // Illegal opcode from requester 0.
      req0_valid = 1'b1; req0_a = 32'd8; req0_b = 32'd2; req0_op = alu_oper_type'(4'b0011);
      cycle();
      req0_valid = 1'b0;
      repeat (4) cycle();

      // Reset during EXEC drops the op; the next request is serviced.
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = ALU_ADD;
      cycle();
      req1_valid = 1'b0; reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (3) cycle();
      req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h8000_0000; req1_op = ALU_SLT;
      cycle();
      req1_valid = 1'b0;
      repeat (4) cycle();

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 400; k++) begin
         if (gnt0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a = rand_bus(); req0_b = rand_bus(); req0_op = rand_op();
         end else if ($urandom_range(0, 7) == 0) begin
            req0_valid = 1'b0;
         end
         if (gnt1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a = rand_bus(); req1_b = rand_bus(); req1_op = rand_op();
         end else if ($urandom_range(0, 7) == 0) begin
            req1_valid = 1'b0;
         end
         resp0_ready = ($urandom_range(0, 4) > 1);
         resp1_ready = ($urandom_range(0, 4) > 1);
         reset       = ($urandom_range(0, 149) == 0);
         cycle();
      end

      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      repeat (6) cycle();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d responses outstanding required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_arbiter
`default_nettype wire
